// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry instruction
// buffer toward decode, and branch/jump redirect with stale-response dropping.
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_b_j,
   input  logic [63:0] dnpc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        id_ready
);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic [1:0]  state_q,     state_d;
   logic [63:0] pc_q,        pc_d;
   logic        req_valid_q, req_valid_d;
   logic        if_valid_q,  if_valid_d;
   logic [63:0] if_pc_q,     if_pc_d;
   logic [31:0] if_inst_q,   if_inst_d;
   logic [63:0] redirect_pc_s;

   assign redirect_pc_s = {dnpc[63:2], 2'b00};

   // Next-state logic; a redirect takes priority over every other event in each state.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d   = if_pc_q;
      if_inst_d = if_inst_q;
      case (state_q)
         ST_REQ: begin
            if (pc_b_j) begin
               pc_d    = redirect_pc_s;
               state_d = imem_req_ready ? ST_DROP : ST_REQ;
            end else if (imem_req_ready) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (pc_b_j) begin
               pc_d    = redirect_pc_s;
               state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
            end else if (imem_rsp_valid) begin
               if_inst_d  = imem_rsp_data;
               if_pc_d    = pc_q;
               pc_d       = pc_q + 64'd4;
               if_valid_d = 1'b1;
               state_d    = ST_HOLD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (pc_b_j) begin
               pc_d       = redirect_pc_s;
               if_valid_d = 1'b0;
               state_d    = ST_REQ;
            end else if (id_ready) begin
               if_valid_d = 1'b0;
               state_d    = ST_REQ;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_DROP: begin
            if (pc_b_j) begin
               pc_d    = redirect_pc_s;
               state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
            end else if (imem_rsp_valid) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d    = ST_REQ;
            if_valid_d = 1'b0;
         end
      endcase
      req_valid_d = (state_d == ST_REQ);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b1;
         if_valid_q  <= 1'b0;
         if_pc_q     <= 64'h0;
         if_inst_q   <= NOP_INST;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_valid_q <= req_valid_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
      end
   end

   // The request flop comes out of reset already set so the first fetch appears
   // immediately after release; masking with rst keeps it quiet while reset is held.
   assign imem_req_valid = req_valid_q & ~rst;
   assign imem_req_addr  = pc_q;
   assign if_valid       = if_valid_q;
   assign if_pc          = if_pc_q;
   assign if_inst        = if_inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table plus a randomized
// handshake sequence, both compared through an expected-output queue.
module tb_ifu_fetch;

   localparam logic [63:0] RP  = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, pc_b_j, imem_req_ready, imem_rsp_valid, id_ready;
   logic [63:0] dnpc;
   logic [31:0] imem_rsp_data;
   logic        imem_req_valid, if_valid;
   logic [63:0] imem_req_addr, if_pc;
   logic [31:0] if_inst;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(RP)) dut (
      .clk(clk), .rst(rst), .pc_b_j(pc_b_j), .dnpc(dnpc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
      .if_inst(if_inst), .id_ready(id_ready)
   );

   typedef struct {
      string       name;
      logic        rst, rdy, rv;
      logic [31:0] rdata;
      logic        bj;
      logic [63:0] dn;
      logic        idr;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_iv;
      logic [63:0] e_ipc;
      logic [31:0] e_inst;
   } vec_t;

   typedef struct {
      string       name;
      logic        rv;
      logic [63:0] addr;
      logic        iv;
      logic [63:0] ipc;
      logic [31:0] inst;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic void add(input string nm, input logic r, input logic rdy, input logic rv,
                               input logic [31:0] rd, input logic bj, input logic [63:0] dn,
                               input logic idr, input logic erv, input logic [63:0] eaddr,
                               input logic eiv, input logic [63:0] eipc, input logic [31:0] einst);
      vec_t v;
      v.name = nm; v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.bj = bj; v.dn = dn;
      v.idr = idr; v.e_rv = erv; v.e_addr = eaddr; v.e_iv = eiv; v.e_ipc = eipc; v.e_inst = einst;
      vecs.push_back(v);
   endfunction

   // Drives one cycle of inputs, queues the expected post-edge outputs, then compares.
   task automatic step(input vec_t v);
      exp_t e, got;
      rst = v.rst; imem_req_ready = v.rdy; imem_rsp_valid = v.rv; imem_rsp_data = v.rdata;
      pc_b_j = v.bj; dnpc = v.dn; id_ready = v.idr;
      e.name = v.name; e.rv = v.e_rv; e.addr = v.e_addr; e.iv = v.e_iv; e.ipc = v.e_ipc;
      e.inst = v.e_inst;
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_total++;
      if (sb.size() == 0) begin
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         got = sb.pop_front();
         if (imem_req_valid === got.rv && imem_req_addr === got.addr && if_valid === got.iv &&
             if_pc === got.ipc && if_inst === got.inst) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got rv=%0b addr=%h iv=%0b pc=%h inst=%h, want rv=%0b addr=%h iv=%0b pc=%h inst=%h",
                     got.name, imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
                     got.rv, got.addr, got.iv, got.ipc, got.inst);
         end
      end
   endtask

   task automatic cyc(input string nm, input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic bj, input logic [63:0] dn, input logic idr,
                      input logic erv, input logic [63:0] eaddr, input logic eiv,
                      input logic [63:0] eipc, input logic [31:0] einst);
      vec_t v;
      v.name = nm; v.rst = 1'b0; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.bj = bj; v.dn = dn;
      v.idr = idr; v.e_rv = erv; v.e_addr = eaddr; v.e_iv = eiv; v.e_ipc = eipc; v.e_inst = einst;
      step(v);
   endtask

   initial begin
      logic [63:0] exp_pc, last_pc;
      logic [31:0] last_inst, data;
      int          n;

      rst = 1'b1; pc_b_j = 1'b0; dnpc = 64'h0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;

      //   name            rst   rdy   rv    rdata            bj    dnpc                    idr   e_rv  e_addr                  e_iv  e_ipc                   e_inst
      add("reset0",        1'b1, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP,                     1'b0, 64'h0,                  NOP);
      add("reset1",        1'b1, 1'b1, 1'b1, 32'h1234_5678,   1'b1, 64'h9000_0000,          1'b1, 1'b0, RP,                     1'b0, 64'h0,                  NOP);
      add("first_req",     1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b1, RP,                     1'b0, 64'h0,                  NOP);
      add("accept",        1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP,                     1'b0, 64'h0,                  NOP);
      add("resp_297",      1'b0, 1'b0, 1'b1, 32'h0000_0297,   1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b1, RP,                     32'h0000_0297);
      add("hold1",         1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b1, RP,                     32'h0000_0297);
      add("hold2_rsp_ign", 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF,   1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b1, RP,                     32'h0000_0297);
      add("hold3",         1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b1, RP,                     32'h0000_0297);
      add("hold4",         1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b1, RP,                     32'h0000_0297);
      add("hold5",         1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b1, RP,                     32'h0000_0297);
      add("release",       1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b1, 1'b1, RP + 64'd4,             1'b0, RP,                     32'h0000_0297);
      add("wait_redir_a",  1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP + 64'd4,             1'b0, RP,                     32'h0000_0297);
      add("wait_redir_b",  1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 64'h8000_0100,          1'b0, 1'b0, 64'h8000_0100,          1'b0, RP,                     32'h0000_0297);
      add("drop_idle",     1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, 64'h8000_0100,          1'b0, RP,                     32'h0000_0297);
      add("drop_rsp",      1'b0, 1'b0, 1'b1, 32'h1111_1111,   1'b0, 64'h0,                  1'b0, 1'b1, 64'h8000_0100,          1'b0, RP,                     32'h0000_0297);
      add("acc_redir",     1'b0, 1'b1, 1'b0, 32'h0,           1'b1, 64'h8000_0203,          1'b0, 1'b0, 64'h8000_0200,          1'b0, RP,                     32'h0000_0297);
      add("acc_redir_rsp", 1'b0, 1'b0, 1'b1, 32'h2222_2222,   1'b0, 64'h0,                  1'b0, 1'b1, 64'h8000_0200,          1'b0, RP,                     32'h0000_0297);
      add("req_rsp_ign",   1'b0, 1'b0, 1'b1, 32'h3333_3333,   1'b0, 64'h0,                  1'b0, 1'b1, 64'h8000_0200,          1'b0, RP,                     32'h0000_0297);
      add("req_redir",     1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 64'h8000_0300,          1'b0, 1'b1, 64'h8000_0300,          1'b0, RP,                     32'h0000_0297);
      add("acc_300",       1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, 64'h8000_0300,          1'b0, RP,                     32'h0000_0297);
      add("rsp_300",       1'b0, 1'b0, 1'b1, 32'h00A0_0093,   1'b0, 64'h0,                  1'b0, 1'b0, 64'h8000_0304,          1'b1, 64'h8000_0300,          32'h00A0_0093);
      add("hold_redir_idr",1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 64'h8000_0400,          1'b1, 1'b1, 64'h8000_0400,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("acc_400",       1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, 64'h8000_0400,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("wait_redir_rsp",1'b0, 1'b0, 1'b1, 32'h4444_4444,   1'b1, 64'h8000_0500,          1'b0, 1'b1, 64'h8000_0500,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("acc_redir_600", 1'b0, 1'b1, 1'b0, 32'h0,           1'b1, 64'h8000_0600,          1'b0, 1'b0, 64'h8000_0600,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("drop_redir_700",1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 64'h8000_0700,          1'b0, 1'b0, 64'h8000_0700,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("drop_redir_rsp",1'b0, 1'b0, 1'b1, 32'h5555_5555,   1'b1, 64'h8000_0800,          1'b0, 1'b1, 64'h8000_0800,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("acc_800",       1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, 64'h8000_0800,          1'b0, 64'h8000_0300,          32'h00A0_0093);
      add("rst_in_wait",   1'b1, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, RP,                     1'b0, 64'h0,                  NOP);
      add("stale_rsp",     1'b0, 1'b0, 1'b1, 32'hBEEF_0001,   1'b0, 64'h0,                  1'b0, 1'b1, RP,                     1'b0, 64'h0,                  NOP);
      add("after_stale",   1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b1, RP,                     1'b0, 64'h0,                  NOP);
      add("redir_top",     1'b0, 1'b0, 1'b0, 32'h0,           1'b1, 64'hFFFF_FFFF_FFFF_FFFF,1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,1'b0, 64'h0,                  NOP);
      add("acc_top",       1'b0, 1'b1, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC,1'b0, 64'h0,                  NOP);
      add("rsp_wrap",      1'b0, 1'b0, 1'b1, 32'h0000_0013,   1'b0, 64'h0,                  1'b0, 1'b0, 64'h0,                  1'b1, 64'hFFFF_FFFF_FFFF_FFFC,NOP);
      add("req_zero",      1'b0, 1'b0, 1'b0, 32'h0,           1'b0, 64'h0,                  1'b1, 1'b1, 64'h0,                  1'b0, 64'hFFFF_FFFF_FFFF_FFFC,NOP);

      foreach (vecs[i]) step(vecs[i]);

      // Randomized handshake timing: ready/response/decode stalls of 0-2 cycles.
      cyc("rnd_redir", 1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_1002, 1'b0,
          1'b1, 64'h8000_1000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, NOP);
      exp_pc    = 64'h8000_1000;
      last_pc   = 64'hFFFF_FFFF_FFFF_FFFC;
      last_inst = NOP;
      for (int k = 0; k < 8; k++) begin
         n = int'($urandom_range(2, 0));
         for (int j = 0; j < n; j++)
            cyc("rnd_req_stall", 1'b0, 1'($urandom_range(1, 0)), $urandom, 1'b0, 64'h0, 1'b0,
                1'b1, exp_pc, 1'b0, last_pc, last_inst);
         cyc("rnd_accept", 1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0,
             1'b0, exp_pc, 1'b0, last_pc, last_inst);
         n = int'($urandom_range(2, 0));
         for (int j = 0; j < n; j++)
            cyc("rnd_wait", 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0,
                1'b0, exp_pc, 1'b0, last_pc, last_inst);
         data = $urandom;
         cyc("rnd_rsp", 1'b0, 1'b1, data, 1'b0, 64'h0, 1'b0,
             1'b0, exp_pc + 64'd4, 1'b1, exp_pc, data);
         last_pc   = exp_pc;
         last_inst = data;
         exp_pc    = exp_pc + 64'd4;
         n = int'($urandom_range(2, 0));
         for (int j = 0; j < n; j++)
            cyc("rnd_hold", 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0,
                1'b0, exp_pc, 1'b1, last_pc, last_inst);
         cyc("rnd_release", 1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1,
             1'b1, exp_pc, 1'b0, last_pc, last_inst);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
